// File: rtl/dna_qga_pkg.sv
// rtl/dna_qga_pkg.sv - shared encodings and FSM state type for the DNA loader
//
// Purpose: base and gate encodings, loader FSM state type and state constants,
//          and a G/C classification helper.
// Ports:   none (package).
package dna_qga_pkg;

  // Base encodings (2 bits per base)
  localparam logic [1:0] BASE_A = 2'b00;
  localparam logic [1:0] BASE_T = 2'b01;
  localparam logic [1:0] BASE_G = 2'b10;
  localparam logic [1:0] BASE_C = 2'b11;

  // Processor gate_select encodings
  localparam logic [1:0] GATE_HADAMARD = 2'b00;
  localparam logic [1:0] GATE_CNOT     = 2'b01;
  localparam logic [1:0] GATE_TOFFOLI  = 2'b10;
  localparam logic [1:0] GATE_CUSTOM   = 2'b11;

  // Dispatch FSM state
  typedef logic [1:0] ld_state_t;
  localparam ld_state_t LD_IDLE    = 2'd0;
  localparam ld_state_t LD_LAUNCH  = 2'd1;
  localparam ld_state_t LD_RELEASE = 2'd2;

  function automatic logic is_gc(input logic [1:0] b);
    return (b == BASE_G) || (b == BASE_C);
  endfunction

endpackage

// File: rtl/dna_word_fifo.sv
// rtl/dna_word_fifo.sv - synchronous FIFO for packed DNA words plus last tag
//
// Purpose: DEPTH-entry FIFO with occupancy count; head visible on o_rdata.
// Ports:
//   clk, rst_n      clock, async active-low reset (drops all entries)
//   i_push, i_wdata write side
//   i_pop, o_rdata  read side (o_rdata is the current head)
//   o_count         number of stored entries
//   o_full, o_empty status flags
module dna_word_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CAP = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CAP);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  // Overflow/underflow requests are ignored rather than corrupting state.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/dna_seq_loader.sv
// rtl/dna_seq_loader.sv - base-stream packer and job dispatcher for dna_quant_processor
//
// Purpose: packs 2-bit bases into DNA_WIDTH-bit words, queues them in
//          dna_word_fifo, runs the processor start/processing_done handshake
//          one word at a time and returns results on a valid/ready port.
//          A watchdog abandons jobs the processor never completes.
// Optional feature macro: DNA_LOADER_GC_COUNT_EN
//          adds gc_min input / res_gc output; head words with fewer than
//          gc_min G/C bases are dropped without being launched.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   gc_min, res_gc          (DNA_LOADER_GC_COUNT_EN only) skip threshold, result G/C count
//   base_valid/ready/data/last  base stream input
//   cfg_aging, cfg_gate     job configuration, sampled at launch
//   proc_start/dna/aging/gate   to processor
//   proc_dna_out/entropy/mutations/done  from processor
//   res_valid/ready/dna/entropy/mutations/last  result stream output
//   err_timeout             sticky watchdog abort flag
//   jobs_done               completed-job counter (wraps)
module dna_seq_loader
  import dna_qga_pkg::*;
#(
  parameter int         DNA_WIDTH          = 32,
  parameter int         AGING_FACTOR_WIDTH = 8,
  parameter int         FIFO_DEPTH         = 4,
  parameter int         TIMEOUT_CYCLES     = 1024,
  parameter logic [1:0] PAD_BASE           = 2'b00
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef DNA_LOADER_GC_COUNT_EN
  input  logic [5:0]                    gc_min,
  output logic [5:0]                    res_gc,
`endif
  input  logic                          base_valid,
  output logic                          base_ready,
  input  logic [1:0]                    base_data,
  input  logic                          base_last,
  input  logic [AGING_FACTOR_WIDTH-1:0] cfg_aging,
  input  logic [1:0]                    cfg_gate,
  output logic                          proc_start,
  output logic [DNA_WIDTH-1:0]          proc_dna,
  output logic [AGING_FACTOR_WIDTH-1:0] proc_aging,
  output logic [1:0]                    proc_gate,
  input  logic [DNA_WIDTH-1:0]          proc_dna_out,
  input  logic [15:0]                   proc_entropy,
  input  logic [7:0]                    proc_mutations,
  input  logic                          proc_done,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [DNA_WIDTH-1:0]          res_dna,
  output logic [15:0]                   res_entropy,
  output logic [7:0]                    res_mutations,
  output logic                          res_last,
  output logic                          err_timeout,
  output logic [15:0]                   jobs_done
);

  localparam int BASES = DNA_WIDTH / 2;
  localparam int IDX_W = (BASES > 1) ? $clog2(BASES) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(BASES - 1);
  localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]     FIFO_CAP = CNT_W'(FIFO_DEPTH);
  localparam logic [DNA_WIDTH-1:0] PAD_WORD = {BASES{PAD_BASE}};

  // ---------------------------------------------------------------- packer
  logic [DNA_WIDTH-1:0] r_pack_word;
  logic [IDX_W-1:0]     r_pack_idx;
  logic [DNA_WIDTH-1:0] w_pack_next;
  logic                 w_base_acc;
  logic                 w_push;

  // FIFO
  logic [DNA_WIDTH:0]   w_fifo_rdata;
  logic [CNT_W-1:0]     w_fifo_count;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic                 w_fifo_pop;
  logic [DNA_WIDTH-1:0] w_head_word;
  logic                 w_head_last;

  // FSM / result
  ld_state_t                     r_state;
  logic [TMR_W-1:0]              r_timer;
  logic                          r_proc_start;
  logic [DNA_WIDTH-1:0]          r_proc_dna;
  logic [AGING_FACTOR_WIDTH-1:0] r_proc_aging;
  logic [1:0]                    r_proc_gate;
  logic                          r_res_valid;
  logic [DNA_WIDTH-1:0]          r_res_dna;
  logic [15:0]                   r_res_entropy;
  logic [7:0]                    r_res_mutations;
  logic                          r_res_last;
  logic                          r_err_timeout;
  logic [15:0]                   r_jobs_done;
  logic                          w_res_free;
  logic                          w_skip;
  logic                          w_launch;
  logic                          w_capture;
  logic                          w_timeout;

  assign base_ready = (w_fifo_count < FIFO_CAP);
  assign w_base_acc = base_valid && base_ready;
  assign w_push     = w_base_acc && (base_last || (r_pack_idx == LAST_IDX));

  // The working word is pre-filled with PAD_BASE, so a short word closed by
  // base_last already carries its padding in the untouched slots.
  always_comb begin
    w_pack_next = r_pack_word;
    w_pack_next[{r_pack_idx, 1'b0} +: 2] = base_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pack_word <= PAD_WORD;
      r_pack_idx  <= '0;
    end else if (w_base_acc) begin
      if (w_push) begin
        r_pack_word <= PAD_WORD;
        r_pack_idx  <= '0;
      end else begin
        r_pack_word <= w_pack_next;
        r_pack_idx  <= r_pack_idx + 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------ FIFO
  // The full gate is redundant with base_ready today; it keeps the FIFO safe
  // if the ready rule is ever relaxed.
  dna_word_fifo #(
    .WIDTH (DNA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push && !w_fifo_full),
    .i_wdata ({base_last, w_pack_next}),
    .i_pop   (w_fifo_pop),
    .o_rdata (w_fifo_rdata),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_head_word = w_fifo_rdata[DNA_WIDTH-1:0];
  assign w_head_last = w_fifo_rdata[DNA_WIDTH];

  // ------------------------------------------------------- G/C skip filter
`ifdef DNA_LOADER_GC_COUNT_EN
  function automatic logic [5:0] gc_of(input logic [DNA_WIDTH-1:0] w);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < BASES; i++) begin
      n = n + 6'(is_gc(w[2*i +: 2]));
    end
    return n;
  endfunction

  logic [5:0] w_head_gc;
  logic [5:0] r_res_gc;

  assign w_head_gc = gc_of(w_head_word);
  assign w_skip    = (r_state == LD_IDLE) && !w_fifo_empty && (w_head_gc < gc_min);
  assign res_gc    = r_res_gc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_gc <= '0;
    end else if (w_capture) begin
      r_res_gc <= gc_of(proc_dna_out);
    end
  end
`else
  assign w_skip = 1'b0;
`endif

  // ---------------------------------------------------------- dispatch FSM
  // A new job may start only if the result slot is free or being drained this
  // cycle; this keeps the result payload from being overwritten while held.
  assign w_res_free = !r_res_valid || res_ready;
  assign w_launch   = (r_state == LD_IDLE) && !w_fifo_empty && w_res_free &&
                      !w_skip && !proc_done;
  assign w_capture  = (r_state == LD_LAUNCH) && proc_done;
  assign w_timeout  = (r_state == LD_LAUNCH) && !proc_done && (r_timer == TMR_LAST);

  // The in-flight word stays at the FIFO head until its job ends, so the head
  // last tag is still the right one at capture time.
  assign w_fifo_pop = w_capture || w_timeout || w_skip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= LD_IDLE;
      r_timer       <= '0;
      r_proc_start  <= 1'b0;
      r_proc_dna    <= '0;
      r_proc_aging  <= '0;
      r_proc_gate   <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      case (r_state)
        LD_IDLE: begin
          if (w_launch) begin
            r_state      <= LD_LAUNCH;
            r_timer      <= '0;
            r_proc_start <= 1'b1;
            r_proc_dna   <= w_head_word;
            r_proc_aging <= cfg_aging;
            r_proc_gate  <= cfg_gate;
          end
        end
        LD_LAUNCH: begin
          if (proc_done) begin
            r_proc_start <= 1'b0;
            r_state      <= LD_RELEASE;
          end else if (w_timeout) begin
            r_proc_start  <= 1'b0;
            r_err_timeout <= 1'b1;
            r_state       <= LD_RELEASE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        LD_RELEASE: begin
          if (!proc_done) r_state <= LD_IDLE;
        end
        default: r_state <= LD_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------- result port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid     <= 1'b0;
      r_res_dna       <= '0;
      r_res_entropy   <= '0;
      r_res_mutations <= '0;
      r_res_last      <= 1'b0;
      r_jobs_done     <= '0;
    end else begin
      if (w_capture) begin
        r_res_valid     <= 1'b1;
        r_res_dna       <= proc_dna_out;
        r_res_entropy   <= proc_entropy;
        r_res_mutations <= proc_mutations;
        r_res_last      <= w_head_last;
        r_jobs_done     <= r_jobs_done + 1'b1;
      end else if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign proc_start    = r_proc_start;
  assign proc_dna      = r_proc_dna;
  assign proc_aging    = r_proc_aging;
  assign proc_gate     = r_proc_gate;
  assign res_valid     = r_res_valid;
  assign res_dna       = r_res_dna;
  assign res_entropy   = r_res_entropy;
  assign res_mutations = r_res_mutations;
  assign res_last      = r_res_last;
  assign err_timeout   = r_err_timeout;
  assign jobs_done     = r_jobs_done;

endmodule

// File: tb/tb_dna_seq_loader.sv
// tb/tb_dna_seq_loader.sv - directed self-checking bench for dna_seq_loader
module tb_dna_seq_loader;
  import dna_qga_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        base_valid;
  logic        base_ready;
  logic [1:0]  base_data;
  logic        base_last;
  logic [7:0]  cfg_aging;
  logic [1:0]  cfg_gate;
  logic        proc_start;
  logic [31:0] proc_dna;
  logic [7:0]  proc_aging;
  logic [1:0]  proc_gate;
  logic [31:0] proc_dna_out;
  logic [15:0] proc_entropy;
  logic [7:0]  proc_mutations;
  logic        proc_done = 1'b0;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_dna;
  logic [15:0] res_entropy;
  logic [7:0]  res_mutations;
  logic        res_last;
  logic        err_timeout;
  logic [15:0] jobs_done;
`ifdef DNA_LOADER_GC_COUNT_EN
  logic [5:0]  gc_min;
  logic [5:0]  res_gc;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // processor model controls
  logic m_en    = 1'b1;
  int   m_delay = 10;
  int   m_cnt   = 0;

  always #5 clk = ~clk;

  dna_seq_loader #(
    .DNA_WIDTH          (32),
    .AGING_FACTOR_WIDTH (8),
    .FIFO_DEPTH         (4),
    .TIMEOUT_CYCLES     (16),
    .PAD_BASE           (2'b00)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef DNA_LOADER_GC_COUNT_EN
    .gc_min         (gc_min),
    .res_gc         (res_gc),
`endif
    .base_valid     (base_valid),
    .base_ready     (base_ready),
    .base_data      (base_data),
    .base_last      (base_last),
    .cfg_aging      (cfg_aging),
    .cfg_gate       (cfg_gate),
    .proc_start     (proc_start),
    .proc_dna       (proc_dna),
    .proc_aging     (proc_aging),
    .proc_gate      (proc_gate),
    .proc_dna_out   (proc_dna_out),
    .proc_entropy   (proc_entropy),
    .proc_mutations (proc_mutations),
    .proc_done      (proc_done),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_dna        (res_dna),
    .res_entropy    (res_entropy),
    .res_mutations  (res_mutations),
    .res_last       (res_last),
    .err_timeout    (err_timeout),
    .jobs_done      (jobs_done)
  );

  // Processor model: swaps A<->T and G<->C, simple entropy/mutation functions.
  function automatic logic [31:0] m_dna(input logic [31:0] w);
    return w ^ 32'h5555_5555;
  endfunction
  function automatic logic [15:0] m_ent(input logic [31:0] w);
    return w[31:16] + w[15:0];
  endfunction
  function automatic logic [7:0] m_mut(input logic [7:0] a, input logic [1:0] g);
    return a ^ {6'b0, g};
  endfunction

  assign proc_dna_out   = m_dna(proc_dna);
  assign proc_entropy   = m_ent(proc_dna);
  assign proc_mutations = m_mut(proc_aging, proc_gate);

  // done rises m_delay cycles after start (counting only while enabled) and
  // falls once start has dropped.
  always @(negedge clk) begin
    if (!proc_start) begin
      proc_done = 1'b0;
      m_cnt     = 0;
    end else if (m_en && !proc_done) begin
      m_cnt = m_cnt + 1;
      if (m_cnt >= m_delay) proc_done = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_base(input logic [1:0] b, input logic last);
    int w;
    w = 0;
    base_valid = 1'b1;
    base_data  = b;
    base_last  = last;
    while (!base_ready && w < 300) begin
      step();
      w++;
    end
    if (!base_ready) chk("send_base_ready", base_ready, 1);
    step();
    base_valid = 1'b0;
    base_last  = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int w;
    w = 0;
    while (!proc_start && w < 200) begin
      step();
      w++;
    end
    chk({tag, "_start"}, proc_start, 1);
  endtask

  task automatic wait_res(input string tag);
    int w;
    w = 0;
    while (!res_valid && w < 300) begin
      step();
      w++;
    end
    chk({tag, "_valid"}, res_valid, 1);
  endtask

  task automatic get_result(input string tag, input logic [31:0] word,
                            input logic [7:0] aging, input logic [1:0] gate,
                            input logic last);
    wait_res(tag);
    chk({tag, "_dna"}, res_dna, m_dna(word));
    chk({tag, "_ent"}, res_entropy, m_ent(word));
    chk({tag, "_mut"}, res_mutations, m_mut(aging, gate));
    chk({tag, "_last"}, res_last, last);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int n;
    logic seen;
    rst_n      = 1'b0;
    base_valid = 1'b0;
    base_data  = 2'b00;
    base_last  = 1'b0;
    cfg_aging  = 8'h3C;
    cfg_gate   = GATE_CNOT;
    res_ready  = 1'b0;
`ifdef DNA_LOADER_GC_COUNT_EN
    gc_min     = 6'd0;
`endif
    repeat (3) step();
    chk("rst_start", proc_start, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_jobs", jobs_done, 0);
    chk("rst_proc_dna", proc_dna, 0);
    rst_n = 1'b1;
    step();
    chk("rst_base_ready", base_ready, 1);

    // 1: sixteen T bases -> 0x55555555, launch one edge after the push
    for (int i = 0; i < 16; i++) send_base(BASE_T, 1'b0);
    chk("t1_no_start_yet", proc_start, 0);
    step();
    chk("t1_start_latency", proc_start, 1);
    chk("t1_proc_dna", proc_dna, 32'h5555_5555);
    chk("t1_proc_aging", proc_aging, 8'h3C);
    chk("t1_proc_gate", proc_gate, GATE_CNOT);
    get_result("t1", 32'h5555_5555, 8'h3C, GATE_CNOT, 1'b0);
    chk("t1_jobs", jobs_done, 1);

    // 2: G,C,T + last -> 0x1E padded with A; config stable after launch
    cfg_aging = 8'hA5;
    cfg_gate  = GATE_TOFFOLI;
    send_base(BASE_G, 1'b0);
    send_base(BASE_C, 1'b0);
    send_base(BASE_T, 1'b1);
    wait_start("t2");
    chk("t2_proc_dna", proc_dna, 32'h0000_001E);
    cfg_aging = 8'h11;
    step();
    chk("t2_aging_stable", proc_aging, 8'hA5);
    get_result("t2", 32'h0000_001E, 8'hA5, GATE_TOFFOLI, 1'b1);
    chk("t2_jobs", jobs_done, 2);

    // 3: fill FIFO with processor stalled, then drain 5 words in order
    m_en    = 1'b0;
    m_delay = 3;
    send_base(BASE_T, 1'b1);
    send_base(BASE_G, 1'b1);
    send_base(BASE_C, 1'b1);
    send_base(BASE_A, 1'b1);
    chk("t3_full_ready", base_ready, 0);
    chk("t3_w1_running", proc_start, 1);
    m_en = 1'b1;
    wait_res("t3_first");
    chk("t3_ready_after_pop", base_ready, 1);
    send_base(BASE_C, 1'b0);
    send_base(BASE_G, 1'b1);
    get_result("t3_w1", 32'h0000_0001, 8'h11, GATE_TOFFOLI, 1'b1);
    get_result("t3_w2", 32'h0000_0002, 8'h11, GATE_TOFFOLI, 1'b1);
    get_result("t3_w3", 32'h0000_0003, 8'h11, GATE_TOFFOLI, 1'b1);
    get_result("t3_w4", 32'h0000_0000, 8'h11, GATE_TOFFOLI, 1'b1);
    get_result("t3_w5", 32'h0000_000B, 8'h11, GATE_TOFFOLI, 1'b1);
    chk("t3_jobs", jobs_done, 7);

    // 4: watchdog abort after 16 cycles, next word still launches
    m_en = 1'b0;
    chk("t4_err_before", err_timeout, 0);
    send_base(BASE_G, 1'b1);
    send_base(BASE_C, 1'b1);
    wait_start("t4_a");
    chk("t4_a_dna", proc_dna, 32'h0000_0002);
    n = 0;
    while (proc_start && n < 100) begin
      step();
      n++;
    end
    chk("t4_tmo_len", n, 16);
    chk("t4_err", err_timeout, 1);
    chk("t4_no_result", res_valid, 0);
    chk("t4_jobs_hold", jobs_done, 7);
    m_en    = 1'b1;
    m_delay = 2;
    wait_start("t4_b");
    chk("t4_b_dna", proc_dna, 32'h0000_0003);
    get_result("t4_b", 32'h0000_0003, 8'h11, GATE_TOFFOLI, 1'b1);
    chk("t4_jobs", jobs_done, 8);

    // 5: reset in LAUNCH clears outputs at once and empties the FIFO
    m_en = 1'b0;
    send_base(BASE_T, 1'b0);
    send_base(BASE_T, 1'b1);
    send_base(BASE_C, 1'b1);
    wait_start("t5");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_start_async", proc_start, 0);
    chk("t5_res_valid", res_valid, 0);
    chk("t5_err_clr", err_timeout, 0);
    chk("t5_jobs_clr", jobs_done, 0);
    step();
    rst_n = 1'b1;
    m_en  = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (proc_start) seen = 1'b1;
    end
    chk("t5_fifo_empty", seen, 0);
    chk("t5_base_ready", base_ready, 1);

`ifdef DNA_LOADER_GC_COUNT_EN
    // 6: low-GC word skipped, high-GC word launched with res_gc
    gc_min  = 6'd8;
    m_delay = 2;
    send_base(BASE_G, 1'b0);
    send_base(BASE_G, 1'b0);
    send_base(BASE_C, 1'b0);
    send_base(BASE_C, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (proc_start) seen = 1'b1;
    end
    chk("t6_skip_no_start", seen, 0);
    for (int i = 0; i < 10; i++) send_base(BASE_C, (i == 9));
    wait_start("t6");
    chk("t6_proc_dna", proc_dna, 32'h000F_FFFF);
    wait_res("t6");
    chk("t6_res_gc", res_gc, 10);
    get_result("t6", 32'h000F_FFFF, 8'h11, GATE_TOFFOLI, 1'b1);
    chk("t6_jobs", jobs_done, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
